// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 message feeder.
package md5_pkg;

    typedef enum logic [2:0] {
        ST_CORE_RST,
        ST_FILL,
        ST_PAD,
        ST_SEND,
        ST_WAIT_DONE
    } state_t;

    localparam int          BLOCK_WORDS = 16;
    localparam int          LEN_LO_IDX  = 14;
    localparam int          LEN_HI_IDX  = 15;
    localparam logic [7:0]  PAD_BYTE    = 8'h80;

endpackage

// File: rtl/md5_block_buf.sv
// 16x32 message block buffer: little-endian byte-lane writes, pad fill,
// full clear, length-word write and a word read port for the send burst.
module md5_block_buf
    import md5_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_byte_we,
    input  logic [5:0]  i_byte_idx,
    input  logic [7:0]  i_byte,
    input  logic        i_pad,
    input  logic        i_clr,
    input  logic        i_len_we,
    input  logic [63:0] i_len,
    input  logic [3:0]  i_rd_idx,
    output logic [31:0] o_rd_word
);

    logic [31:0] r_words [BLOCK_WORDS];

    // Pad writes 0x80 at the pointer and zeros every later byte; the length
    // write is placed last so it overrides pad/clear in words 14 and 15.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int w = 0; w < BLOCK_WORDS; w++) begin
                r_words[w] <= '0;
            end
        end else begin
            for (int w = 0; w < BLOCK_WORDS; w++) begin
                for (int l = 0; l < 4; l++) begin
                    if (i_clr) begin
                        r_words[w][8*l +: 8] <= 8'h00;
                    end else if (i_pad && (i_byte_idx == 6'(4*w + l))) begin
                        r_words[w][8*l +: 8] <= PAD_BYTE;
                    end else if (i_pad && (6'(4*w + l) > i_byte_idx)) begin
                        r_words[w][8*l +: 8] <= 8'h00;
                    end else if (i_byte_we && (i_byte_idx == 6'(4*w + l))) begin
                        r_words[w][8*l +: 8] <= i_byte;
                    end
                end
            end
            if (i_len_we) begin
                r_words[LEN_LO_IDX] <= i_len[31:0];
                r_words[LEN_HI_IDX] <= i_len[63:32];
            end
        end
    end

    assign o_rd_word = r_words[i_rd_idx];

endmodule

// File: rtl/md5_msg_feeder.sv
// Byte-stream front end for the md5sum core: MD5 padding, block packing,
// 16-word write bursts, per-message core reset and digest capture.
module md5_msg_feeder
    import md5_pkg::*;
#(
    parameter int LEN_W      = 32,
    parameter int RST_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         core_rst_n,
    input  logic         core_rdy,
    output logic         core_write_en,
    output logic [31:0]  core_msg,
    input  logic         core_done,
    input  logic [31:0]  core_a,
    input  logic [31:0]  core_b,
    input  logic [31:0]  core_c,
    input  logic [31:0]  core_d,
    output logic [127:0] digest,
    output logic         digest_valid,
    output logic         busy
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [RC_W-1:0]   r_rst_cnt;
    logic [LEN_W-1:0]  r_byte_cnt;
    logic [5:0]        r_ptr;
    logic [3:0]        r_send_cnt;
    logic              r_write_en;
    logic              r_final;
    logic              r_len_pending;
    logic              r_last_pending;
    logic [127:0]      r_digest;
    logic              r_digest_valid;
    logic              r_busy;

    logic              w_accept;
    logic              w_rst_done;
    logic              w_byte_we;
    logic              w_pad;
    logic              w_clr;
    logic              w_len_we;
    logic              w_len_fits;
    logic [63:0]       w_bitlen;
    logic [31:0]       w_rd_word;

    assign w_accept   = in_valid && (r_state == ST_FILL);
    assign w_rst_done = (r_rst_cnt == RC_W'(RST_CYCLES - 1));
    assign w_len_fits = (r_ptr <= 6'd55);
    assign w_bitlen   = {{(61 - LEN_W){1'b0}}, r_byte_cnt, 3'b000};

    md5_block_buf u_buf (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_byte_we  (w_byte_we),
        .i_byte_idx (r_ptr),
        .i_byte     (in_data),
        .i_pad      (w_pad),
        .i_clr      (w_clr),
        .i_len_we   (w_len_we),
        .i_len      (w_bitlen),
        .i_rd_idx   (r_send_cnt),
        .o_rd_word  (w_rd_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_CORE_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_byte_we   = 1'b0;
        w_pad       = 1'b0;
        w_clr       = 1'b0;
        w_len_we    = 1'b0;
        case (r_state)
            ST_CORE_RST: begin
                if (w_rst_done) w_state_nxt = ST_FILL;
            end
            ST_FILL: begin
                if (w_accept) begin
                    w_byte_we = 1'b1;
                    if (r_ptr == 6'd63)  w_state_nxt = ST_SEND;
                    else if (in_last)    w_state_nxt = ST_PAD;
                end
            end
            ST_PAD: begin
                w_pad       = 1'b1;
                w_len_we    = w_len_fits;
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (r_write_en && (r_send_cnt == 4'd15)) w_state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (core_done) begin
                    if (r_final) begin
                        w_clr       = 1'b1;
                        w_state_nxt = ST_CORE_RST;
                    end else if (r_len_pending) begin
                        w_clr       = 1'b1;
                        w_len_we    = 1'b1;
                        w_state_nxt = ST_SEND;
                    end else if (r_last_pending) begin
                        w_state_nxt = ST_PAD;
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end
            end
            default: w_state_nxt = ST_CORE_RST;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_cnt      <= '0;
            r_byte_cnt     <= '0;
            r_ptr          <= '0;
            r_send_cnt     <= '0;
            r_write_en     <= 1'b0;
            r_final        <= 1'b0;
            r_len_pending  <= 1'b0;
            r_last_pending <= 1'b0;
            r_digest       <= '0;
            r_digest_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_digest_valid <= 1'b0;
            case (r_state)
                ST_CORE_RST: begin
                    r_rst_cnt      <= w_rst_done ? '0 : r_rst_cnt + RC_W'(1);
                    r_byte_cnt     <= '0;
                    r_ptr          <= '0;
                    r_final        <= 1'b0;
                    r_len_pending  <= 1'b0;
                    r_last_pending <= 1'b0;
                end
                ST_FILL: begin
                    if (w_accept) begin
                        r_byte_cnt <= r_byte_cnt + LEN_W'(1);
                        r_ptr      <= r_ptr + 6'd1;
                        r_busy     <= 1'b1;
                        if (in_last) r_last_pending <= 1'b1;
                    end
                end
                ST_PAD: begin
                    r_last_pending <= 1'b0;
                    r_ptr          <= '0;
                    if (w_len_fits) r_final       <= 1'b1;
                    else            r_len_pending <= 1'b1;
                end
                ST_SEND: begin
                    // core_rdy only starts a burst; once started it runs 16 words.
                    if (!r_write_en) begin
                        if (core_rdy) begin
                            r_write_en <= 1'b1;
                            r_send_cnt <= '0;
                        end
                    end else if (r_send_cnt == 4'd15) begin
                        r_write_en <= 1'b0;
                        r_send_cnt <= '0;
                    end else begin
                        r_send_cnt <= r_send_cnt + 4'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (core_done) begin
                        if (r_final) begin
                            r_digest       <= {core_a, core_b, core_c, core_d};
                            r_digest_valid <= 1'b1;
                            r_busy         <= 1'b0;
                            r_final        <= 1'b0;
                        end else if (r_len_pending) begin
                            r_len_pending <= 1'b0;
                            r_final       <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready      = (r_state == ST_FILL);
    assign core_rst_n    = (r_state != ST_CORE_RST);
    assign core_write_en = r_write_en;
    assign core_msg      = r_write_en ? w_rd_word : 32'h0;
    assign digest        = r_digest;
    assign digest_valid  = r_digest_valid;
    assign busy          = r_busy;

endmodule

// File: tb/tb_md5_msg_feeder.sv
// Scoreboard bench for md5_msg_feeder with a behavioural md5sum core model.
module tb_md5_msg_feeder;

    localparam logic [127:0] IV = 128'h67452301_efcdab89_98badcfe_10325476;
    localparam int SH [16] = '{7,12,17,22, 5,9,14,20, 4,11,16,23, 6,10,15,21};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic         core_rst_n;
    logic         core_rdy;
    logic         core_write_en;
    logic [31:0]  core_msg;
    logic         core_done;
    logic [31:0]  core_a, core_b, core_c, core_d;
    logic [127:0] digest;
    logic         digest_valid;
    logic         busy;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [31:0]  exp_words[$];
    logic [127:0] exp_digests[$];
    logic [7:0]   msg[$];
    logic [31:0]  K[64];
    logic         hold_rdy = 1'b0;
    int           gap_max  = 0;

    always #5 clk = ~clk;

    md5_msg_feeder #(.LEN_W(32), .RST_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .core_rst_n    (core_rst_n),
        .core_rdy      (core_rdy),
        .core_write_en (core_write_en),
        .core_msg      (core_msg),
        .core_done     (core_done),
        .core_a        (core_a),
        .core_b        (core_b),
        .core_c        (core_c),
        .core_d        (core_d),
        .digest        (digest),
        .digest_valid  (digest_valid),
        .busy          (busy)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    function automatic logic [127:0] md5_blk(input logic [127:0] st, input logic [511:0] blk);
        logic [31:0] a, b, c, d, f;
        int g, s;
        a = st[127:96]; b = st[95:64]; c = st[63:32]; d = st[31:0];
        for (int i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (b & c) | (~b & d); g = i;               end
            else if (i < 32) begin f = (d & b) | (~d & c); g = (5*i + 1) % 16;  end
            else if (i < 48) begin f = b ^ c ^ d;          g = (3*i + 5) % 16;  end
            else             begin f = c ^ (b | ~d);       g = (7*i) % 16;      end
            s = SH[(i/16)*4 + (i%4)];
            f = f + a + K[i] + blk[32*g +: 32];
            a = d; d = c; c = b;
            b = b + ((f << s) | (f >> (32 - s)));
        end
        return {st[127:96] + a, st[95:64] + b, st[63:32] + c, st[31:0] + d};
    endfunction

    // Reference: standard MD5 padding applied to the whole message at once.
    task automatic build_expect(output logic [127:0] st);
        logic [7:0]      p[$];
        longint unsigned bl;
        logic [511:0]    blk;
        logic [31:0]     w;
        p  = msg;
        bl = longint'(msg.size()) * 8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 0; i < 8; i++) p.push_back(8'(bl >> (8*i)));
        st = IV;
        for (int j = 0; j < p.size()/64; j++) begin
            for (int k = 0; k < 16; k++) begin
                w = {p[64*j+4*k+3], p[64*j+4*k+2], p[64*j+4*k+1], p[64*j+4*k]};
                exp_words.push_back(w);
                blk[32*k +: 32] = w;
            end
            st = md5_blk(st, blk);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
    endtask

    task automatic drive_msg();
        int wt;
        for (int i = 0; i < msg.size(); i++) begin
            @(negedge clk);
            if (gap_max > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = msg[i];
            in_last  = (i == msg.size() - 1);
            wt = 0;
            while (!in_ready && wt < 2000) begin
                @(negedge clk);
                wt++;
            end
            if (!in_ready) begin
                fail_now("in_ready_timeout");
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int wt;
        wt = 0;
        while (exp_digests.size() != 0 && wt < 5000) begin
            @(negedge clk);
            wt++;
        end
        if (exp_digests.size() != 0) fail_now("digest_timeout");
        check("words_left", 128'(exp_words.size()), 128'd0);
        exp_words.delete();
        exp_digests.delete();
        @(negedge clk);
    endtask

    task automatic run_msg(input logic use_const, input logic [127:0] cdig);
        logic [127:0] st;
        build_expect(st);
        exp_digests.push_back(use_const ? cdig : st);
        drive_msg();
        wait_idle();
    endtask

    // Monitor: every write beat and every digest pulse pops the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (core_write_en) begin
                    if (exp_words.size() == 0) fail_now("unexpected_write");
                    else check("core_msg", 128'(core_msg), 128'(exp_words.pop_front()));
                    check("busy_in_send", 128'(busy), 128'd1);
                    check("in_ready_in_send", 128'(in_ready), 128'd0);
                end
                if (digest_valid) begin
                    if (exp_digests.size() == 0) fail_now("unexpected_digest");
                    else check("digest", digest, exp_digests.pop_front());
                end
            end
        end
    end

    // Behavioural md5sum core: collects a 16-word burst, hashes, pulses done.
    initial begin : core_model
        int           wcnt;
        int           cphase;
        int           lat;
        logic [511:0] cblk;
        logic [127:0] cst;
        wcnt = 0; cphase = 0; lat = 0; cblk = '0; cst = IV;
        core_rdy = 1'b0; core_done = 1'b0;
        core_a = '0; core_b = '0; core_c = '0; core_d = '0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (!core_rst_n) begin
                cst = IV; cphase = 0; wcnt = 0; core_rdy = 1'b0;
            end else if (cphase == 0) begin
                if (core_write_en) begin
                    if (wcnt == 0 && !core_rdy) fail_now("write_without_rdy");
                    if (wcnt < 16) cblk[32*wcnt +: 32] = core_msg;
                    wcnt++;
                end else if (wcnt > 0) begin
                    check("burst_len", 128'(wcnt), 128'd16);
                    cst      = md5_blk(cst, cblk);
                    wcnt     = 0;
                    core_rdy = 1'b0;
                    cphase   = 1;
                    lat      = int'($urandom_range(12, 3));
                end
                if (cphase == 0 && wcnt == 0) core_rdy = !hold_rdy;
            end else begin
                lat--;
                if (lat == 0) begin
                    {core_a, core_b, core_c, core_d} = cst;
                    core_done = 1'b1;
                    cphase    = 0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol_we, viol_rdy, cnt, wt;
        for (int i = 0; i < 64; i++) begin
            real x;
            x = $sin(real'(i + 1));
            if (x < 0.0) x = -x;
            K[i] = 32'(longint'($floor(x * 4294967296.0)));
        end

        repeat (2) @(negedge clk);
        check("rst_in_ready",      128'(in_ready),      128'd0);
        check("rst_core_rst_n",    128'(core_rst_n),    128'd0);
        check("rst_write_en",      128'(core_write_en), 128'd0);
        check("rst_core_msg",      128'(core_msg),      128'd0);
        check("rst_digest",        digest,              128'd0);
        check("rst_digest_valid",  128'(digest_valid),  128'd0);
        check("rst_busy",          128'(busy),          128'd0);
        rst = 1'b0;

        msg.delete(); push_str("hello");
        run_msg(1'b1, 128'h2a40415d_762a4bbc_919d71b9_92c51710);

        msg.delete(); push_str("hello");
        for (int i = 0; i < 109; i++) msg.push_back(8'h20);
        push_str("world");
        run_msg(1'b1, 128'h3e9bf178_d8e32df5_c353bf0d_d2e0876c);

        msg.delete();
        for (int i = 0; i < 56; i++) msg.push_back(8'h61);
        run_msg(1'b0, '0);

        msg.delete();
        for (int i = 0; i < 64; i++) msg.push_back(8'h00);
        run_msg(1'b0, '0);

        gap_max = 3;
        foreach (SH[j]) begin
            int lens [8] = '{55, 57, 63, 64, 65, 119, 128, 1};
            if (j < 8) begin
                msg.delete();
                for (int i = 0; i < lens[j]; i++) msg.push_back(8'($urandom));
                run_msg(1'b0, '0);
            end
        end
        for (int m = 0; m < 5; m++) begin
            msg.delete();
            for (int i = 0; i < int'($urandom_range(200, 1)); i++) msg.push_back(8'($urandom));
            run_msg(1'b0, '0);
        end

        // Core holds rdy low while the first block of a 70-byte message waits.
        gap_max = 0;
        begin
            logic [127:0] st;
            msg.delete();
            for (int i = 0; i < 70; i++) msg.push_back(8'($urandom));
            build_expect(st);
            exp_digests.push_back(st);
            hold_rdy = 1'b1;
            viol_we = 0; viol_rdy = 0;
            fork
                drive_msg();
                begin
                    for (int c = 0; c < 180; c++) begin
                        @(negedge clk);
                        if (core_write_en) viol_we++;
                        if (c >= 80 && in_ready) viol_rdy++;
                    end
                    hold_rdy = 1'b0;
                end
            join
            check("hold_write_en", 128'(viol_we), 128'd0);
            check("hold_in_ready", 128'(viol_rdy), 128'd0);
            wait_idle();
        end

        // Reset during the 8th write beat aborts the message.
        begin
            logic [127:0] st;
            msg.delete(); push_str("hello");
            build_expect(st);
            exp_digests.push_back(st);
            drive_msg();
            cnt = 0; wt = 0;
            while (cnt < 8 && wt < 500) begin
                @(negedge clk);
                wt++;
                if (core_write_en) cnt++;
            end
            if (cnt < 8) fail_now("reset_test_no_burst");
            #2 rst = 1'b1;
            #1;
            check("arst_in_ready",     128'(in_ready),      128'd0);
            check("arst_core_rst_n",   128'(core_rst_n),    128'd0);
            check("arst_write_en",     128'(core_write_en), 128'd0);
            check("arst_core_msg",     128'(core_msg),      128'd0);
            check("arst_digest_valid", 128'(digest_valid),  128'd0);
            check("arst_busy",         128'(busy),          128'd0);
            exp_words.delete();
            exp_digests.delete();
            repeat (3) @(negedge clk);
            rst = 1'b0;
            repeat (20) @(negedge clk);
        end

        msg.delete(); push_str("hello");
        run_msg(1'b1, 128'h2a40415d_762a4bbc_919d71b9_92c51710);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
